axi_lite_arbiter: RTL and testbench

Round-robin AXI4-Lite arbiter that shares one downstream AXI4-Lite port between NUM_MASTERS upstream masters, e.g. IFU and LSU ahead of the address crossbar. One transaction, read or write, is outstanding at a time. The winning master holds the grant from address acceptance through its response handshake. Non-granted masters are fully stalled.

---
 rtl/axi_lite_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one downstream AXI4-Lite port between
// NUM_MASTERS upstream masters. Only one read or write transaction is
// outstanding at a time. The granted master keeps its grant until its
// response handshake completes.

package axi_lite_arbiter_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;
endpackage

module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS),
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  // Upstream masters: read address / read data
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   m_araddr_i,
  input  logic [NUM_MASTERS-1:0]               m_arvalid_i,
  output logic [NUM_MASTERS-1:0]               m_arready_o,
  output logic [NUM_MASTERS-1:0][DATA_W-1:0]   m_rdata_o,
  output logic [NUM_MASTERS-1:0][1:0]          m_rresp_o,
  output logic [NUM_MASTERS-1:0]               m_rvalid_o,
  input  logic [NUM_MASTERS-1:0]               m_rready_i,
  // Upstream masters: write address / write data / write response
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   m_awaddr_i,
  input  logic [NUM_MASTERS-1:0]               m_awvalid_i,
  output logic [NUM_MASTERS-1:0]               m_awready_o,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]   m_wdata_i,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0] m_wmask_i,
  input  logic [NUM_MASTERS-1:0]               m_wvalid_i,
  output logic [NUM_MASTERS-1:0]               m_wready_o,
  output logic [NUM_MASTERS-1:0][1:0]          m_bresp_o,
  output logic [NUM_MASTERS-1:0]               m_bvalid_o,
  input  logic [NUM_MASTERS-1:0]               m_bready_i,
  // Shared downstream port
  output logic [ADDR_W-1:0]                    s_araddr_o,
  output logic                                 s_arvalid_o,
  input  logic                                 s_arready_i,
  input  logic [DATA_W-1:0]                    s_rdata_i,
  input  logic [1:0]                           s_rresp_i,
  input  logic                                 s_rvalid_i,
  output logic                                 s_rready_o,
  output logic [ADDR_W-1:0]                    s_awaddr_o,
  output logic                                 s_awvalid_o,
  input  logic                                 s_awready_i,
  output logic [DATA_W-1:0]                    s_wdata_o,
  output logic [DATA_W/8-1:0]                  s_wmask_o,
  output logic                                 s_wvalid_o,
  input  logic                                 s_wready_i,
  input  logic [1:0]                           s_bresp_i,
  input  logic                                 s_bvalid_i,
  output logic                                 s_bready_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  logic [NUM_MASTERS-1:0] rd_req, wr_req, req;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W:0]         cand_sum;
  logic [IDX_W-1:0]       cand_idx;
  logic                   ar_fire, r_fire, aw_fire, w_fire, b_fire;

  assign rd_req = m_arvalid_i;
  assign wr_req = m_awvalid_i;
  assign req    = rd_req | wr_req;

  // Round-robin search starting at ptr; the loop runs from the farthest
  // candidate to the nearest so the nearest requester overwrites the result.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (cand_sum >= (IDX_W + 1)'(NUM_MASTERS)) begin
        cand_sum = cand_sum - (IDX_W + 1)'(NUM_MASTERS);
      end
      cand_idx = cand_sum[IDX_W-1:0];
      if (req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and forwarding logic; all forwarding is combinational
  // through the granted master's lane.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case statement leaves a signal unassigned (no latches).
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    ar_fire     = 1'b0;
    r_fire      = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    b_fire      = 1'b0;

    m_arready_o = '0;
    m_rdata_o   = '0;
    m_rresp_o   = '0;
    m_rvalid_o  = '0;
    m_awready_o = '0;
    m_wready_o  = '0;
    m_bresp_o   = '0;
    m_bvalid_o  = '0;

    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    s_awvalid_o = 1'b0;
    s_wvalid_o  = 1'b0;
    s_bready_o  = 1'b0;

    // Address and data fields always follow the granted master; they are
    // qualified by the valids below.
    s_araddr_o  = m_araddr_i[gnt_idx_q];
    s_awaddr_o  = m_awaddr_i[gnt_idx_q];
    s_wdata_o   = m_wdata_i[gnt_idx_q];
    s_wmask_o   = m_wmask_i[gnt_idx_q];

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_idx_d = win_idx;
          ptr_d     = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
          state_d   = rd_req[win_idx] ? ST_RD_ADDR : ST_WR_ADDR;
        end
      end

      ST_RD_ADDR: begin
        s_arvalid_o            = m_arvalid_i[gnt_idx_q];
        m_arready_o[gnt_idx_q] = s_arready_i;
        ar_fire                = m_arvalid_i[gnt_idx_q] & s_arready_i;
        if (ar_fire) state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        s_rready_o             = m_rready_i[gnt_idx_q];
        m_rvalid_o[gnt_idx_q]  = s_rvalid_i;
        m_rdata_o[gnt_idx_q]   = s_rdata_i;
        m_rresp_o[gnt_idx_q]   = s_rresp_i;
        r_fire                 = s_rvalid_i & m_rready_i[gnt_idx_q];
        if (r_fire) state_d = ST_IDLE;
      end

      ST_WR_ADDR: begin
        // A channel that has already handshaken is masked off downstream.
        s_awvalid_o            = m_awvalid_i[gnt_idx_q] & ~aw_done_q;
        m_awready_o[gnt_idx_q] = s_awready_i & ~aw_done_q;
        s_wvalid_o             = m_wvalid_i[gnt_idx_q] & ~w_done_q;
        m_wready_o[gnt_idx_q]  = s_wready_i & ~w_done_q;
        aw_fire                = m_awvalid_i[gnt_idx_q] & ~aw_done_q & s_awready_i;
        w_fire                 = m_wvalid_i[gnt_idx_q] & ~w_done_q & s_wready_i;
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          state_d   = ST_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_fire;
          w_done_d  = w_done_q | w_fire;
        end
      end

      ST_WR_RESP: begin
        s_bready_o             = m_bready_i[gnt_idx_q];
        m_bvalid_o[gnt_idx_q]  = s_bvalid_i;
        m_bresp_o[gnt_idx_q]   = s_bresp_i;
        b_fire                 = s_bvalid_i & m_bready_i[gnt_idx_q];
        if (b_fire) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; asynchronous reset forces IDLE so every valid/ready
  // output drops immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so all registers update from the
      // same pre-edge values regardless of statement order.
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter with two masters.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.

module tb_axi_lite_arbiter;
  import axi_lite_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic reset;

  logic [N-1:0][AW-1:0]   m_araddr;
  logic [N-1:0]           m_arvalid, m_arready;
  logic [N-1:0][DW-1:0]   m_rdata;
  logic [N-1:0][1:0]      m_rresp;
  logic [N-1:0]           m_rvalid, m_rready;
  logic [N-1:0][AW-1:0]   m_awaddr;
  logic [N-1:0]           m_awvalid, m_awready;
  logic [N-1:0][DW-1:0]   m_wdata;
  logic [N-1:0][DW/8-1:0] m_wmask;
  logic [N-1:0]           m_wvalid, m_wready;
  logic [N-1:0][1:0]      m_bresp;
  logic [N-1:0]           m_bvalid, m_bready;

  logic [AW-1:0]   s_araddr;
  logic            s_arvalid, s_arready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rvalid, s_rready;
  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid, s_awready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wmask;
  logic            s_wvalid, s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid, s_bready;

  int checks = 0;
  int errors = 0;

  axi_lite_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .m_araddr_i  (m_araddr),
    .m_arvalid_i (m_arvalid),
    .m_arready_o (m_arready),
    .m_rdata_o   (m_rdata),
    .m_rresp_o   (m_rresp),
    .m_rvalid_o  (m_rvalid),
    .m_rready_i  (m_rready),
    .m_awaddr_i  (m_awaddr),
    .m_awvalid_i (m_awvalid),
    .m_awready_o (m_awready),
    .m_wdata_i   (m_wdata),
    .m_wmask_i   (m_wmask),
    .m_wvalid_i  (m_wvalid),
    .m_wready_o  (m_wready),
    .m_bresp_o   (m_bresp),
    .m_bvalid_o  (m_bvalid),
    .m_bready_i  (m_bready),
    .s_araddr_o  (s_araddr),
    .s_arvalid_o (s_arvalid),
    .s_arready_i (s_arready),
    .s_rdata_i   (s_rdata),
    .s_rresp_i   (s_rresp),
    .s_rvalid_i  (s_rvalid),
    .s_rready_o  (s_rready),
    .s_awaddr_o  (s_awaddr),
    .s_awvalid_o (s_awvalid),
    .s_awready_i (s_awready),
    .s_wdata_o   (s_wdata),
    .s_wmask_o   (s_wmask),
    .s_wvalid_o  (s_wvalid),
    .s_wready_i  (s_wready),
    .s_bresp_i   (s_bresp),
    .s_bvalid_i  (s_bvalid),
    .s_bready_o  (s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_e exp);
    check(tag, 64'(dut.state_q), 64'(exp));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_araddr  = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr  = '0; m_awvalid = '0;
    m_wdata   = '0; m_wmask   = '0; m_wvalid = '0;
    m_bready  = '0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0;
    s_bresp   = '0;   s_bvalid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [1:0] exp_gnt [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- Reset behaviour ----------------
    reset = 1'b0;
    clear_inputs();
    m_arvalid[0] = 1'b1;
    m_araddr[0]  = 32'h1000_0040;
    s_arready    = 1'b1;
    #2;
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_m0_arready", m_arready[0], 0);
    check_state("rst_state", ST_IDLE);
    for (int i = 0; i < 3; i++) begin
      tick();
      m_arvalid[0] = ~m_arvalid[0];
      #1;
      check("rst_toggle_s_arvalid", s_arvalid, 0);
    end
    tick();
    m_arvalid[0] = 1'b1;
    reset = 1'b1;
    #1;
    check("rel_no_comb_path", s_arvalid, 0);
    check_state("rel_state_idle", ST_IDLE);
    tick();
    check("rel_s_arvalid", s_arvalid, 1);
    check("rel_s_araddr", s_araddr, 32'h1000_0040);
    check("rel_m0_arready", m_arready[0], 1);
    // Asynchronous assertion mid-transaction must clear outputs at once.
    reset = 1'b0;
    #1;
    check("async_s_arvalid", s_arvalid, 0);
    check("async_m0_arready", m_arready[0], 0);
    check_state("async_state", ST_IDLE);
    check("async_ptr", dut.ptr_q, 0);

    // ---------------- Single read, zero-wait slave ----------------
    apply_reset();
    m_arvalid[1] = 1'b1;
    m_araddr[1]  = 32'h8000_0010;
    m_rready     = 2'b11;
    s_arready    = 1'b1;
    s_rvalid     = 1'b1;
    s_rdata      = 32'hDEAD_BEEF;
    s_rresp      = 2'b00;
    #1;
    check_state("rd_c0_state", ST_IDLE);
    check("rd_c0_rvalid", m_rvalid, 0);
    tick();
    check_state("rd_c1_state", ST_RD_ADDR);
    check("rd_c1_arready", m_arready, 2'b10);
    check("rd_c1_s_araddr", s_araddr, 32'h8000_0010);
    check("rd_c1_rvalid", m_rvalid, 0);
    check("rd_c1_s_rready", s_rready, 0);
    tick();
    m_arvalid[1] = 1'b0;
    #1;
    check_state("rd_c2_state", ST_RD_DATA);
    check("rd_c2_rvalid", m_rvalid, 2'b10);
    check("rd_c2_m1_rdata", m_rdata[1], 32'hDEAD_BEEF);
    check("rd_c2_m1_rresp", m_rresp[1], 0);
    check("rd_c2_m0_rdata", m_rdata[0], 0);
    check("rd_c2_s_rready", s_rready, 1);
    tick();
    check_state("rd_c3_state", ST_IDLE);
    check("rd_c3_rvalid", m_rvalid, 0);

    // ---------------- Contention, round-robin ----------------
    apply_reset();
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    m_arvalid   = 2'b11;
    m_araddr[0] = 32'h0000_1000;
    m_araddr[1] = 32'h0000_2000;
    m_rready    = 2'b11;
    s_arready   = 1'b1;
    s_rvalid    = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("rr_gnt%0d", t), m_arready, exp_gnt[t]);
      check($sformatf("rr_addr%0d", t), s_araddr,
            (exp_gnt[t] == 2'b01) ? 32'h0000_1000 : 32'h0000_2000);
      tick();
      tick();
    end

    // ---------------- Write, W before AW ----------------
    apply_reset();
    m_wvalid[0] = 1'b1;
    m_wdata[0]  = 32'h1234_5678;
    m_wmask[0]  = 4'hF;
    m_bready    = 2'b11;
    s_wready    = 1'b1;
    s_awready   = 1'b0;
    tick();
    check("wr_w_only_s_wvalid", s_wvalid, 0);
    check_state("wr_w_only_state", ST_IDLE);
    tick();
    m_awvalid[0] = 1'b1;
    m_awaddr[0]  = 32'hA000_03F8;
    tick();
    check_state("wr_a_state", ST_WR_ADDR);
    check("wr_a_s_wvalid", s_wvalid, 1);
    check("wr_a_s_wdata", s_wdata, 32'h1234_5678);
    check("wr_a_s_wmask", s_wmask, 4'hF);
    check("wr_a_wready", m_wready, 2'b01);
    check("wr_a_s_awvalid", s_awvalid, 1);
    check("wr_a_s_awaddr", s_awaddr, 32'hA000_03F8);
    check("wr_a_awready", m_awready, 2'b00);
    tick();
    check("wr_b_s_wvalid_masked", s_wvalid, 0);
    check("wr_b_wready", m_wready, 0);
    check("wr_b_s_awvalid", s_awvalid, 1);
    check_state("wr_b_state", ST_WR_ADDR);
    tick();
    check_state("wr_c_state_hold", ST_WR_ADDR);
    s_awready = 1'b1;
    #1;
    check("wr_c_awready", m_awready, 2'b01);
    tick();
    m_awvalid[0] = 1'b0;
    m_wvalid[0]  = 1'b0;
    s_bvalid     = 1'b1;
    s_bresp      = 2'b00;
    #1;
    check_state("wr_d_state", ST_WR_RESP);
    check("wr_d_s_awvalid", s_awvalid, 0);
    check("wr_d_bvalid", m_bvalid, 2'b01);
    check("wr_d_m0_bresp", m_bresp[0], 0);
    check("wr_d_s_bready", s_bready, 1);
    tick();
    check_state("wr_e_state", ST_IDLE);
    check("wr_e_bvalid", m_bvalid, 0);

    // ---------------- Read/write mix on master 0 ----------------
    apply_reset();
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h0000_0100;
    m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h0000_0200;
    m_wvalid[0]  = 1'b1; m_wdata[0]  = 32'h5555_AAAA; m_wmask[0] = 4'h3;
    m_rready[0]  = 1'b1; m_bready[0] = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    tick();
    check_state("mix_rd_addr", ST_RD_ADDR);
    check("mix_rd_s_awvalid", s_awvalid, 0);
    check("mix_rd_bvalid", m_bvalid, 0);
    tick();
    m_arvalid[0] = 1'b0;
    #1;
    check_state("mix_rd_data", ST_RD_DATA);
    check("mix_rd_rdata", m_rdata[0], 32'h0BAD_F00D);
    tick();
    check_state("mix_idle_gap", ST_IDLE);
    check("mix_idle_s_awvalid", s_awvalid, 0);
    tick();
    check_state("mix_wr_addr", ST_WR_ADDR);
    check("mix_wr_s_awaddr", s_awaddr, 32'h0000_0200);
    check("mix_wr_s_wvalid", s_wvalid, 1);
    tick();
    m_awvalid[0] = 1'b0;
    m_wvalid[0]  = 1'b0;
    #1;
    check_state("mix_wr_resp", ST_WR_RESP);
    check("mix_wr_bvalid", m_bvalid, 2'b01);
    tick();
    check_state("mix_done", ST_IDLE);

    // ---------------- Backpressure and error response ----------------
    apply_reset();
    m_arvalid[1] = 1'b1; m_araddr[1] = 32'h4000_0008;
    m_araddr[0]  = 32'h3000_0004;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rresp = 2'b10; s_rdata = 32'hCAFE_0001;
    m_rready  = 2'b00;
    tick();
    check("bp_gnt_m1", m_arready, 2'b10);
    tick();
    m_arvalid[1] = 1'b0;
    m_arvalid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_state($sformatf("bp_state%0d", k), ST_RD_DATA);
      check($sformatf("bp_rresp%0d", k), m_rresp[1], 2'b10);
      check($sformatf("bp_rvalid%0d", k), m_rvalid, 2'b10);
      check($sformatf("bp_s_rready%0d", k), s_rready, 0);
      check($sformatf("bp_m0_arready%0d", k), m_arready[0], 0);
      check($sformatf("bp_s_arvalid%0d", k), s_arvalid, 0);
      tick();
    end
    check_state("bp_still_rd_data", ST_RD_DATA);
    m_rready[1] = 1'b1;
    #1;
    check("bp_release_s_rready", s_rready, 1);
    tick();
    check_state("bp_idle", ST_IDLE);
    check("bp_idle_m0_arready", m_arready[0], 0);
    tick();
    check_state("bp_m0_rd_addr", ST_RD_ADDR);
    check("bp_m0_arready", m_arready, 2'b01);
    check("bp_m0_araddr", s_araddr, 32'h3000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
